// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion, one round key per clock.
// Optional round-key register file is enabled by defining AES_KEY_STORE_EN.
module aes_key_schedule #(
    parameter int WIDTH = 128,
    parameter int NR    = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             key_valid_i,
    input  logic [WIDTH-1:0] key_i,
    output logic             busy_o,
    output logic             rkey_valid_o,
    output logic [3:0]       rkey_idx_o,
    output logic [WIDTH-1:0] rkey_o,
    output logic             done_o,
    input  logic [3:0]       rd_idx_i,
    output logic [WIDTH-1:0] rd_key_o,
    output logic             dbg_state_o
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [3:0] LAST_IDX = 4'(NR);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t           state_q;
    logic             busy_q, valid_q, done_q;
    logic [3:0]       idx_q;
    logic [7:0]       rcon_q, rcon_d;
    logic [WIDTH-1:0] rkey_q, next_key_d;
    logic [31:0]      rot_w, t_w, n0, n1, n2, n3;

    // Next round key from the key currently on rkey_q, using this round's rcon.
    always_comb begin
        rot_w = {rkey_q[23:0], rkey_q[31:24]};
        t_w   = {SBOX[rot_w[31:24]], SBOX[rot_w[23:16]], SBOX[rot_w[15:8]], SBOX[rot_w[7:0]]}
              ^ {rcon_q, 24'h0};
        n0    = rkey_q[127:96] ^ t_w;
        n1    = rkey_q[95:64]  ^ n0;
        n2    = rkey_q[63:32]  ^ n1;
        n3    = rkey_q[31:0]   ^ n2;
        next_key_d = {n0, n1, n2, n3};
        rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
    end

    // key_valid_i is a start pulse with no ready: it is taken only while
    // busy_o is low, and a pulse seen while busy_o is high is simply dropped.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= 4'd0;
            rcon_q  <= 8'h01;
            rkey_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (key_valid_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        idx_q   <= 4'd0;
                        rcon_q  <= 8'h01;
                        rkey_q  <= key_i;
                    end
                end
                S_RUN: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        idx_q  <= idx_q + 4'd1;
                        rkey_q <= next_key_d;
                        rcon_q <= rcon_d;
                        done_q <= (idx_q == LAST_IDX - 4'd1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign rkey_valid_o = valid_q;
    assign rkey_idx_o   = idx_q;
    assign rkey_o       = rkey_q;
    assign done_o       = done_q;
    assign dbg_state_o  = state_q;

`ifdef AES_KEY_STORE_EN
    logic [WIDTH-1:0] store_q [0:NR];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k <= NR; k++) store_q[k] <= '0;
        end else if (state_q == S_IDLE && key_valid_i) begin
            store_q[0] <= key_i;
        end else if (state_q == S_RUN && idx_q != LAST_IDX) begin
            store_q[idx_q + 4'd1] <= next_key_d;
        end
    end

    assign rd_key_o = (rd_idx_i <= LAST_IDX) ? store_q[rd_idx_i] : '0;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^rd_idx_i;
    assign rd_key_o      = '0;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Testbench for aes_key_schedule: FIPS-197 key expansion reference model with
// a scoreboard queue, known-answer vectors, restart, drop and reset-abort cases.
module tb_aes_key_schedule;
    localparam int W = 133;  // {idx[3:0], round key[127:0], done}

    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         key_valid_i = 1'b0;
    logic [127:0] key_i = '0;
    logic         busy_o, rkey_valid_o, done_o, dbg_state_o;
    logic [3:0]   rkey_idx_o;
    logic [127:0] rkey_o, rd_key_o;
    logic [3:0]   rd_idx_i = 4'd0;

    aes_key_schedule dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .key_valid_i(key_valid_i), .key_i(key_i),
        .busy_o(busy_o), .rkey_valid_o(rkey_valid_o), .rkey_idx_o(rkey_idx_o),
        .rkey_o(rkey_o), .done_o(done_o), .rd_idx_i(rd_idx_i), .rd_key_o(rd_key_o),
        .dbg_state_o(dbg_state_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] exp_q[$];
    int           idx0_cyc[$];
    logic [W-1:0] got_e, exp_e;
    logic [7:0]   sbox_tab [256];
    logic [127:0] model_rk [11];

    localparam logic [127:0] K_FIPS  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K_FIPS1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K_FIPSA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K_SEC   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K_ZERO1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] K_ZEROA = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    // ---------------- reference model (GF(2^8) arithmetic) ----------------
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int c = 1; c < 256; c++)
                if (x != 0 && gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // FIPS-197 KeyExpansion over w[0..43], then one scoreboard entry per round key.
    task automatic push_expected(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                       sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int k = 0; k < 11; k++) begin
            model_rk[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
            exp_q.push_back({4'(k), model_rk[k], (k == 10)});
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            n_checks++;
            if (busy_o !== rkey_valid_o) begin
                n_errors++;
                $display("FAIL busy_track: busy_o %b rkey_valid_o %b at cycle %0d", busy_o, rkey_valid_o, cyc);
            end
            if (rkey_valid_o) begin
                if (rkey_idx_o == 4'd0) idx0_cyc.push_back(cyc);
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_rkey: got idx %0d key %h with nothing expected", rkey_idx_o, rkey_o);
                end else begin
                    exp_e = exp_q.pop_front();
                    got_e = {rkey_idx_o, rkey_o, done_o};
                    if (got_e !== exp_e) begin
                        n_errors++;
                        $display("FAIL rkey_stream: got %h expected %h", got_e, exp_e);
                    end
                end
            end else begin
                n_checks++;
                if (done_o !== 1'b0) begin
                    n_errors++;
                    $display("FAIL done_idle: got done_o %b expected 0", done_o);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_key(input logic [127:0] key);
        @(negedge clk_i);
        key_valid_i = 1'b1;
        key_i       = key;
        push_expected(key);
        @(negedge clk_i);
        key_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 100) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        n_checks++;
        if (exp_q.size() != 0 || busy_o) begin
            n_errors++;
            $display("FAIL idle_timeout: got %0d pending keys busy %b expected 0 pending idle", exp_q.size(), busy_o);
            exp_q.delete();
        end
    endtask

    task automatic check_rd(input int idx);
        logic [127:0] exp = '0;
        rd_idx_i = 4'(idx);
        #1;
`ifdef AES_KEY_STORE_EN
        if (idx <= 10) exp = model_rk[idx];
`endif
        check($sformatf("rd_key[%0d]", idx), rd_key_o, exp);
    endtask

    // Known-answer run with explicit cycle-by-cycle checks; optionally pulses a
    // second key during the run, which must be ignored.
    task automatic run_known(input logic [127:0] key, input logic [127:0] exp1,
                             input logic [127:0] exp10, input bit inject);
        start_key(key);
        #1;
        check("idx0_key", rkey_o, key);
        check("idx0_idx", {124'h0, rkey_idx_o}, 128'd0);
        check("idx0_busy", {127'h0, busy_o}, 128'd1);
        @(negedge clk_i);
        #1;
        check("idx1_key", rkey_o, exp1);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            if (inject && i == 2) begin
                key_valid_i = 1'b1;
                key_i       = K_SEC;
            end else begin
                key_valid_i = 1'b0;
            end
        end
        #1;
        check("idx10_key", rkey_o, exp10);
        check("idx10_idx", {124'h0, rkey_idx_o}, 128'd10);
        check("idx10_done", {127'h0, done_o}, 128'd1);
        @(negedge clk_i);
        #1;
        check("end_busy", {127'h0, busy_o}, 128'd0);
        check("end_valid", {127'h0, rkey_valid_o}, 128'd0);
        check("end_done", {127'h0, done_o}, 128'd0);
        check("end_hold_key", rkey_o, exp10);
        check("end_hold_idx", {124'h0, rkey_idx_o}, 128'd10);
        wait_idle();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0;
        build_sbox();

        // Reset state
        repeat (3) @(negedge clk_i);
        #1;
        check("rst_busy", {127'h0, busy_o}, 128'd0);
        check("rst_valid", {127'h0, rkey_valid_o}, 128'd0);
        check("rst_idx", {124'h0, rkey_idx_o}, 128'd0);
        check("rst_rkey", rkey_o, 128'd0);
        check("rst_done", {127'h0, done_o}, 128'd0);
        check("rst_rdkey", rd_key_o, 128'd0);
        rst_n_i = 1'b1;

        // FIPS-197 vector and readback of the stored round keys
        run_known(K_FIPS, K_FIPS1, K_FIPSA, 1'b0);
        check_rd(1);
        check_rd(10);
        check_rd(15);
        check_rd(0);

        // Second key pulsed mid-run must be dropped
        run_known(K_FIPS, K_FIPS1, K_FIPSA, 1'b1);
        repeat (3) @(negedge clk_i);
        #1;
        check("drop_no_restart", {127'h0, busy_o}, 128'd0);

        // key_valid_i held high: back-to-back runs with a single idle gap
        @(negedge clk_i);
        key_valid_i = 1'b1;
        key_i       = {$urandom, $urandom, $urandom, $urandom};
        push_expected(key_i);
        push_expected(key_i);
        n0 = idx0_cyc.size();
        for (int n = 0; n < 40 && idx0_cyc.size() < n0 + 2; n++) begin
            @(negedge clk_i);
            #1;
        end
        key_valid_i = 1'b0;
        n_checks++;
        if (idx0_cyc.size() < n0 + 2) begin
            n_errors++;
            $display("FAIL hold_restart: got %0d idx0 starts expected 2", idx0_cyc.size() - n0);
        end else begin
            check("restart_gap", 128'(idx0_cyc[n0+1] - idx0_cyc[n0]), 128'd12);
        end
        wait_idle();

        // Reset asserted mid-expansion aborts immediately
        start_key({$urandom, $urandom, $urandom, $urandom});
        repeat (5) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        exp_q.delete();
        check("abort_busy", {127'h0, busy_o}, 128'd0);
        check("abort_valid", {127'h0, rkey_valid_o}, 128'd0);
        check("abort_done", {127'h0, done_o}, 128'd0);
        check("abort_rkey", rkey_o, 128'd0);
        check("abort_idx", {124'h0, rkey_idx_o}, 128'd0);
        rd_idx_i = 4'd3;
        #1;
        check("abort_rdkey", rd_key_o, 128'd0);
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
        run_known(K_FIPS, K_FIPS1, K_FIPSA, 1'b0);

        // All-zero key
        run_known(128'd0, K_ZERO1, K_ZEROA, 1'b0);
        check_rd(5);

        // Random keys with random idle gaps
        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk_i);
            start_key({$urandom, $urandom, $urandom, $urandom});
            wait_idle();
            check_rd($urandom_range(0, 15));
        end

        repeat (3) @(negedge clk_i);
        check("final_drain", 128'(exp_q.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
